// File: rtl/dvfs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_pkg
// Purpose  : Shared power-mode constants, voltage/frequency encodings, the
//            request-arbiter FSM state encoding and level helper functions.
// Contents : MODE_*     - power mode / performance level codes
//            VOLTAGE_*  - voltage codes driven on force_voltage
//            FREQ_*     - frequency codes driven on force_freq
//            arb_state_e, sat_level(), level_to_freq(), level_to_voltage()
// Revision : 1.0 - initial release
// ============================================================================
package dvfs_pkg;

  localparam logic [1:0] MODE_DEEPSLEEP = 2'd0;
  localparam logic [1:0] MODE_STANDBY   = 2'd1;
  localparam logic [1:0] MODE_ACTIVE    = 2'd2;

  localparam logic [1:0] VOLTAGE_LOW    = 2'd0;
  localparam logic [1:0] VOLTAGE_MID    = 2'd1;
  localparam logic [1:0] VOLTAGE_HIGH   = 2'd2;

  localparam logic [1:0] FREQ_MIN       = 2'd0;
  localparam logic [1:0] FREQ_LOW       = 2'd1;
  localparam logic [1:0] FREQ_MAX       = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

  // Code 3 is not a real mode; it is folded onto Active.
  function automatic logic [1:0] sat_level(input logic [1:0] level);
    return (level == 2'd3) ? MODE_ACTIVE : level;
  endfunction

  function automatic logic [1:0] level_to_freq(input logic [1:0] level);
    logic [1:0] freq;
    case (sat_level(level))
      MODE_ACTIVE:  freq = FREQ_MAX;
      MODE_STANDBY: freq = FREQ_LOW;
      default:      freq = FREQ_MIN;
    endcase
    return freq;
  endfunction

  function automatic logic [1:0] level_to_voltage(input logic [1:0] level);
    logic [1:0] volt;
    case (sat_level(level))
      MODE_ACTIVE:  volt = VOLTAGE_HIGH;
      MODE_STANDBY: volt = VOLTAGE_MID;
      default:      volt = VOLTAGE_LOW;
    endcase
    return volt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvfs_vote_max.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_vote_max
// Purpose  : Combinational reducer returning the highest saturated vote among
//            the valid requesters and the lowest index holding that vote.
// Ports    : req_valid [NUM_REQ]   - requester i holds a vote
//            req_level [2*NUM_REQ] - vote i in bits [2i+1:2i]
//            agg_level [2]         - max saturated vote, 0 when none valid
//            max_idx   [3]         - lowest max-holder index, 0 when none valid
// Revision : 1.0 - initial release
// ============================================================================
module dvfs_vote_max
  import dvfs_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_level,
  output logic [1:0]           agg_level,
  output logic [2:0]           max_idx
);

  logic found;

  // Strict '>' after the first hit keeps the lowest index on ties; 'found'
  // lets an all-DeepSleep vote set still report its lowest valid holder.
  always_comb begin
    agg_level = MODE_DEEPSLEEP;
    max_idx   = 3'd0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (!found || (sat_level(req_level[2*i +: 2]) > agg_level))) begin
        agg_level = sat_level(req_level[2*i +: 2]);
        max_idx   = 3'(i);
        found     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dvfs_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_request_arbiter
// Purpose  : Aggregates requester performance votes into a single power mode,
//            drives the dvfs_controller force interface, enforces a dwell
//            time before downscaling and acknowledges satisfied votes.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_level  - requester votes (in)
//            req_ack              - vote i currently satisfied (out)
//            force_mode_valid/force_voltage/force_freq - to controller (out)
//            dvfs_ready/irq_mode_changed/current_power_mode - from controller
//            applied_level, owner_id, busy, err_timeout (out), err_clear (in)
// Revision : 1.0 - initial release
// ============================================================================
module dvfs_request_arbiter
  import dvfs_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int MIN_DWELL_CYCLES   = 1000,
  parameter int ACK_TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_level,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 force_mode_valid,
  output logic [1:0]           force_voltage,
  output logic [1:0]           force_freq,
  input  logic                 dvfs_ready,
  input  logic                 irq_mode_changed,
  input  logic [1:0]           current_power_mode,
  output logic [1:0]           applied_level,
  output logic [2:0]           owner_id,
  output logic                 busy,
  output logic                 err_timeout,
  input  logic                 err_clear
);

  localparam int DWELL_W = (MIN_DWELL_CYCLES > 0) ? $clog2(MIN_DWELL_CYCLES + 1) : 1;
  localparam int TMO_W   = (ACK_TIMEOUT_CYCLES > 0) ? $clog2(ACK_TIMEOUT_CYCLES + 1) : 1;

  logic [1:0] agg_level;
  logic [2:0] max_idx;

  dvfs_vote_max #(.NUM_REQ(NUM_REQ)) u_vote_max (
    .req_valid (req_valid),
    .req_level (req_level),
    .agg_level (agg_level),
    .max_idx   (max_idx)
  );

  arb_state_e         state_q, state_d;
  logic [1:0]         target_q, target_d;
  logic               force_valid_q, force_valid_d;
  logic [1:0]         force_voltage_q, force_voltage_d;
  logic [1:0]         force_freq_q, force_freq_d;
  logic [1:0]         applied_q, applied_d;
  logic [2:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               done_hit, tmo_hit;

  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    force_valid_d   = force_valid_q;
    force_voltage_d = force_voltage_q;
    force_freq_d    = force_freq_q;
    applied_d       = applied_q;
    busy_d          = busy_q;
    tmo_d           = tmo_q;
    done_hit        = 1'b0;
    tmo_hit         = 1'b0;
    owner_d         = max_idx;
    dwell_d         = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

    case (state_q)
      ST_IDLE: begin
        // Upscales go straight out; downscales wait for the dwell to drain.
        if ((agg_level > applied_q) || ((agg_level < applied_q) && (dwell_q == '0)))
          state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        target_d        = agg_level;
        force_voltage_d = level_to_voltage(agg_level);
        force_freq_d    = level_to_freq(agg_level);
        force_valid_d   = 1'b1;
        busy_d          = 1'b1;
        tmo_d           = TMO_W'(ACK_TIMEOUT_CYCLES);
        state_d         = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        tmo_d = (tmo_q == '0) ? '0 : tmo_q - TMO_W'(1);
        if (!dvfs_ready)
          state_d = ST_WAIT_DONE;
        else if (tmo_q == '0)
          tmo_hit = 1'b1;
      end
      ST_WAIT_DONE: begin
        tmo_d = (tmo_q == '0) ? '0 : tmo_q - TMO_W'(1);
        if (irq_mode_changed && (current_power_mode == target_q))
          done_hit = 1'b1;
        else if (tmo_q == '0)
          tmo_hit = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_hit) begin
      applied_d = target_q;
      dwell_d   = DWELL_W'(MIN_DWELL_CYCLES);
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end
    if (tmo_hit) begin
      // Resynchronise with whatever mode the controller actually reports.
      applied_d = current_power_mode;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end

    // A fresh timeout overrides a coincident clear.
    err_d = tmo_hit | (err_q & ~err_clear);

    for (int i = 0; i < NUM_REQ; i++)
      ack_d[i] = req_valid[i] && (sat_level(req_level[2*i +: 2]) <= applied_q)
                 && (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      target_q        <= MODE_ACTIVE;
      force_valid_q   <= 1'b0;
      force_voltage_q <= VOLTAGE_HIGH;
      force_freq_q    <= FREQ_MAX;
      applied_q       <= MODE_ACTIVE;
      owner_q         <= 3'd0;
      ack_q           <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      dwell_q         <= DWELL_W'(MIN_DWELL_CYCLES);
      tmo_q           <= '0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      force_valid_q   <= force_valid_d;
      force_voltage_q <= force_voltage_d;
      force_freq_q    <= force_freq_d;
      applied_q       <= applied_d;
      owner_q         <= owner_d;
      ack_q           <= ack_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      dwell_q         <= dwell_d;
      tmo_q           <= tmo_d;
    end
  end

  assign req_ack          = ack_q;
  assign force_mode_valid = force_valid_q;
  assign force_voltage    = force_voltage_q;
  assign force_freq       = force_freq_q;
  assign applied_level    = applied_q;
  assign owner_id         = owner_q;
  assign busy             = busy_q;
  assign err_timeout      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dvfs_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvfs_request_arbiter
// Purpose  : Self-checking bench for dvfs_request_arbiter. The bench plays the
//            dvfs_controller and predicts arbiter behaviour from the mode rules
//            (max vote, dwell before downscale, ack when satisfied).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvfs_request_arbiter;

  localparam int N = 4;
  localparam int D = 12;
  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [2*N-1:0] req_level = '0;
  logic [N-1:0] req_ack;
  logic         force_mode_valid;
  logic [1:0]   force_voltage, force_freq;
  logic         dvfs_ready = 1'b1;
  logic         irq_mode_changed = 1'b0;
  logic [1:0]   current_power_mode = 2'd2;
  logic [1:0]   applied_level;
  logic [2:0]   owner_id;
  logic         busy, err_timeout;
  logic         err_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int reload_cyc = 0;
  int exp_applied = 2;
  int exp_fv = 2;
  int exp_ff = 3;

  dvfs_request_arbiter #(
    .NUM_REQ(N), .MIN_DWELL_CYCLES(D), .ACK_TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
    .req_ack(req_ack), .force_mode_valid(force_mode_valid),
    .force_voltage(force_voltage), .force_freq(force_freq),
    .dvfs_ready(dvfs_ready), .irq_mode_changed(irq_mode_changed),
    .current_power_mode(current_power_mode), .applied_level(applied_level),
    .owner_id(owner_id), .busy(busy), .err_timeout(err_timeout),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference rules ----------------
  function automatic int lvl(int i);
    int l;
    l = int'(req_level[2*i +: 2]);
    return (l == 3) ? 2 : l;
  endfunction

  function automatic int ref_agg();
    int m = 0;
    for (int i = 0; i < N; i++) if (req_valid[i] && lvl(i) > m) m = lvl(i);
    return m;
  endfunction

  function automatic int ref_owner();
    int a = ref_agg();
    for (int i = 0; i < N; i++) if (req_valid[i] && lvl(i) == a) return i;
    return 0;
  endfunction

  function automatic int ref_freq(int l);
    return (l == 2) ? 3 : (l == 1) ? 1 : 0;
  endfunction

  function automatic logic [N-1:0] ref_ack(int applied);
    logic [N-1:0] a = '0;
    for (int i = 0; i < N; i++) a[i] = req_valid[i] && (lvl(i) <= applied);
    return a;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vote(input int i, input bit v, input int l);
    req_valid[i] = v;
    req_level[2*i +: 2] = 2'(l);
  endtask

  // Votes were changed in cycle v; predict the cycle force_* show tgt.
  task automatic wait_issue(input int v, input int tgt, input string tag);
    int e;
    if (tgt < exp_applied) e = ((v > reload_cyc + D) ? v : reload_cyc + D) + 2;
    else e = v + 2;
    while (cyc < e - 1) tick();
    chk({tag, "_pre_voltage"}, force_voltage, exp_fv);
    chk({tag, "_pre_busy"}, busy, 0);
    tick();
    chk({tag, "_voltage"}, force_voltage, tgt);
    chk({tag, "_freq"}, force_freq, ref_freq(tgt));
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_fmv"}, force_mode_valid, 1);
    chk({tag, "_owner"}, owner_id, ref_owner());
    exp_fv = tgt;
    exp_ff = ref_freq(tgt);
  endtask

  // Controller model: random ready-drop and completion latency.
  task automatic ctrl_complete(input int tgt, input bit hook, input string tag);
    int lr, ld;
    lr = $urandom_range(0, 3);
    ld = $urandom_range(1, 4);
    for (int k = 0; k < lr; k++) begin
      tick();
      chk({tag, "_hold_v"}, force_voltage, exp_fv);
    end
    dvfs_ready = 1'b0;
    for (int k = 0; k < ld; k++) begin
      tick();
      chk({tag, "_hold_v2"}, force_voltage, exp_fv);
      chk({tag, "_hold_f2"}, force_freq, exp_ff);
      chk({tag, "_ack_inflight"}, req_ack, 0);
      if (hook && k == 0) set_vote(1, 1'b1, 2);
    end
    current_power_mode = 2'(tgt);
    irq_mode_changed = 1'b1;
    tick();
    irq_mode_changed = 1'b0;
    dvfs_ready = 1'b1;
    chk({tag, "_applied"}, applied_level, tgt);
    chk({tag, "_busy_done"}, busy, 0);
    exp_applied = tgt;
    reload_cyc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, a;
    // ---- reset ----
    repeat (3) tick();
    chk("rst_fmv", force_mode_valid, 0);
    chk("rst_voltage", force_voltage, 2);
    chk("rst_freq", force_freq, 3);
    chk("rst_applied", applied_level, 2);
    chk("rst_owner", owner_id, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    reload_cyc = cyc;

    // ---- req0 votes Active: already applied, just ack ----
    set_vote(0, 1'b1, 2);
    tick(); tick();
    chk("t1_ack0", req_ack[0], 1);
    chk("t1_busy", busy, 0);
    chk("t1_fmv", force_mode_valid, 0);

    // ---- req0 drops to Standby: waits out the dwell ----
    set_vote(0, 1'b1, 1);
    v = cyc;
    wait_issue(v, 1, "t2");
    ctrl_complete(1, 1'b0, "t2");
    tick();
    chk("t2_ack0", req_ack[0], 1);

    // ---- req2 raises Active while dwell is running: immediate ----
    set_vote(2, 1'b1, 2);
    v = cyc;
    wait_issue(v, 2, "t3");
    ctrl_complete(2, 1'b0, "t3");

    // ---- vote change during WAIT_DONE: second transition after ----
    set_vote(2, 1'b0, 0);
    set_vote(1, 1'b1, 0);
    v = cyc;
    wait_issue(v, 1, "t4a");
    ctrl_complete(1, 1'b1, "t4a");
    wait_issue(cyc, 2, "t4b");
    ctrl_complete(2, 1'b0, "t4b");

    // ---- controller never drops ready: timeout ----
    set_vote(1, 1'b0, 0);
    v = cyc;
    wait_issue(v, 1, "t5");
    a = cyc;
    while (cyc < a + T) tick();
    chk("t5_err_before", err_timeout, 0);
    chk("t5_busy_before", busy, 1);
    set_vote(0, 1'b1, 2);
    tick();
    chk("t5_err", err_timeout, 1);
    chk("t5_busy", busy, 0);
    chk("t5_applied", applied_level, current_power_mode);
    chk("t5_force_hold", force_voltage, 1);
    exp_applied = 2;
    tick();
    chk("t5_err_sticky", err_timeout, 1);
    chk("t5_no_reissue", busy, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t5_err_cleared", err_timeout, 0);

    // ---- no valid votes: DeepSleep ----
    req_valid = '0;
    v = cyc;
    wait_issue(v, 0, "t6");
    ctrl_complete(0, 1'b0, "t6");
    tick();
    chk("t6_ack", req_ack, 0);

    // ---- reset in the middle of a transition ----
    set_vote(3, 1'b1, 1);
    wait_issue(cyc, 1, "t7");
    rst_n = 1'b0;
    #1;
    chk("t7_rst_fmv", force_mode_valid, 0);
    chk("t7_rst_voltage", force_voltage, 2);
    chk("t7_rst_freq", force_freq, 3);
    chk("t7_rst_applied", applied_level, 2);
    chk("t7_rst_busy", busy, 0);
    tick();
    current_power_mode = 2'd2;
    dvfs_ready = 1'b1;
    rst_n = 1'b1;
    reload_cyc = cyc;
    exp_applied = 2; exp_fv = 2; exp_ff = 3;

    // ---- random votes whose max stays Active: owner and acks ----
    for (int it = 0; it < 10; it++) begin
      int k;
      req_valid = N'($urandom);
      req_level = (2*N)'($urandom);
      k = $urandom_range(0, N - 1);
      set_vote(k, 1'b1, 2 + $urandom_range(0, 1));
      tick(); tick();
      chk("r_owner", owner_id, ref_owner());
      chk("r_ack", req_ack, ref_ack(exp_applied));
      chk("r_busy", busy, 0);
    end

    // ---- random votes with transitions ----
    for (int it = 0; it < 8; it++) begin
      req_valid = N'($urandom);
      req_level = (2*N)'($urandom);
      a = ref_agg();
      v = cyc;
      if (a == exp_applied) begin
        tick(); tick();
        chk("rt_idle_busy", busy, 0);
        chk("rt_idle_ack", req_ack, ref_ack(exp_applied));
      end else begin
        wait_issue(v, a, "rt");
        ctrl_complete(a, 1'b0, "rt");
        tick();
        chk("rt_ack", req_ack, ref_ack(exp_applied));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dvfs_request_arbiter.md
# dvfs_request_arbiter

Aggregates performance-level votes from up to NUM_REQ requesters (CPU, CIM, DMA, host link) into one power mode and drives the force interface of `dvfs_controller`. It holds the requested mode stable until the controller confirms the transition. It enforces a minimum dwell time before any downscale and acknowledges each requester once its level is in effect. It sits between the requester bus and `dvfs_controller`, and replaces direct software writes to `force_*`.

## Interface
- NUM_REQ, 4, number of requesters (1–8)
- MIN_DWELL_CYCLES, 1000, minimum cycles after a completed transition before a downscale may issue
- ACK_TIMEOUT_CYCLES, 4096, maximum cycles to wait for the controller before flagging an error
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i holds a vote
- req_level  in  2*NUM_REQ  vote of requester i in bits [2i+1:2i]: 0=DeepSleep, 1=Standby, 2=Active, 3 is treated as 2
- req_ack  out  NUM_REQ  level-type: vote i is currently satisfied
- force_mode_valid  out  1  to `dvfs_controller`
- force_voltage  out  2  to `dvfs_controller`
- force_freq  out  2  to `dvfs_controller`
- dvfs_ready  in  1  from `dvfs_controller`
- irq_mode_changed  in  1  1-cycle completion pulse from `dvfs_controller`
- current_power_mode  in  2  from `dvfs_controller`
- applied_level  out  2  last confirmed mode
- owner_id  out  3  lowest index among the requesters holding the maximum vote
- busy  out  1  a transition is in flight
- err_timeout  out  1  sticky flag: the controller did not respond in time
- err_clear  in  1  clears err_timeout

## Operation
- Aggregate level agg = max of sat(req_level[i]) over all valid i, where sat maps 3 to 2. With no valid votes, agg = 0.
- Frequency map: level 2 → freq 3, level 1 → freq 1, level 0 → freq 0. force_voltage always equals the target level.
- The dwell counter loads MIN_DWELL_CYCLES at reset and at every completion, then decrements to 0 and saturates there.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE → ISSUE when either condition holds:
  - agg > applied_level (upscale, issued immediately), or
  - agg < applied_level and dwell == 0 (downscale).
- ISSUE, one cycle:
  - latch target = agg;
  - register force_voltage and force_freq;
  - set force_mode_valid = 1 and leave it high permanently afterwards;
  - busy = 1;
  - load the timeout counter.
- WAIT_START:
  - dvfs_ready == 0 → WAIT_DONE;
  - timeout expiry → IDLE with error handling (below).
- WAIT_DONE:
  - irq_mode_changed && current_power_mode == target → applied_level = target, reload dwell, busy = 0, go to IDLE;
  - timeout expiry → IDLE with error handling.
- Error handling on timeout: set err_timeout, applied_level = current_power_mode, busy = 0.
- The force_* values never change outside ISSUE. Vote changes during a transition are evaluated only after the return to IDLE.
- Simultaneous err_clear and a new timeout: set wins.
- req_ack[i] is registered and equals req_valid[i] && sat(level_i) <= applied_level && state == IDLE.
- owner_id is registered each cycle from the current votes and reads 0 when no vote is valid.

## Timing
- Reset values:
  - force_mode_valid 0, force_voltage 2, force_freq 3;
  - applied_level 2, owner_id 0;
  - req_ack 0, busy 0, err_timeout 0;
  - state IDLE.
- Upscale latency: the vote appears in cycle N, force_* are valid at N+2 (IDLE decision, then ISSUE register). busy rises at N+2.
- req_ack for an upscaled vote rises one cycle after the IDLE return that follows the completion pulse.
- A vote that is dropped and re-raised within a transition produces no extra transition unless agg still differs from applied_level after completion.
- Timeout counter:
  - loads ACK_TIMEOUT_CYCLES in ISSUE and decrements in the WAIT states;
  - expiry occurs on the cycle it reads 0;
  - it is not reloaded between WAIT_START and WAIT_DONE.
- Reset asserted mid-transition returns all outputs to their reset values immediately. The controller is itself reset and restarts in Active, so the two stay consistent.

## Structure
- Shared package `dvfs_pkg` holds:
  - the MODE_DEEPSLEEP, MODE_STANDBY and MODE_ACTIVE constants;
  - the VOLTAGE_* constants;
  - a level-to-freq function, also used by `dvfs_controller` users;
  - the FSM state encoding.
- Sub-module `dvfs_vote_max`: a combinational reducer over NUM_REQ votes that outputs agg and the index of the lowest max-holder.
- The arbiter itself contains the FSM, the dwell and timeout counters, and the ack registers.

## Test plan
- Reset, then req0 votes 2. Required: no transition, because applied_level is already 2, and req_ack[0] = 1 within 2 cycles.
- req0 = 1 only, dwell still running. Required: force_voltage stays 2 until dwell reaches 0, then force_voltage = 1 and force_freq = 1; after the model's completion pulse, applied_level = 1 and busy = 0.
- In Standby with dwell active, req2 raises 2. Required: immediate issue with force_voltage = 2, force_freq = 3 and owner_id = 2, with no dwell wait.
- During WAIT_DONE, req1 changes its vote from 0 to 2. Required: force_* stay unchanged until completion, then a second transition issues.
- Model never deasserts dvfs_ready. Required: after ACK_TIMEOUT_CYCLES, err_timeout = 1, applied_level = current_power_mode, state IDLE; a pulse on err_clear clears the flag.
- No valid votes and dwell expired. Required: target 0 is issued, and after completion req_ack = 0 for all requesters.
